// File: rtl/rand_byte_packer_if.sv
// Symbol input, word output and status bundle for rand_byte_packer.
// slave = packer side, master = symbol source / word consumer side.
interface rand_byte_packer_if #(
    parameter int SYM_W      = 2,
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    logic              i_sym_valid;
    logic [SYM_W-1:0]  i_sym;
    logic              i_clr;
    logic [WORD_W-1:0] o_word;
    logic              o_word_valid;
    logic              i_word_ready;
    logic [LVL_W-1:0]  o_level;
    logic              o_overflow;
    logic              o_stuck;

    modport master (
        output i_sym_valid, i_sym, i_clr, i_word_ready,
        input  o_word, o_word_valid, o_level, o_overflow, o_stuck
    );

    modport slave (
        input  i_sym_valid, i_sym, i_clr, i_word_ready,
        output o_word, o_word_valid, o_level, o_overflow, o_stuck
    );
endinterface

// File: rtl/rand_byte_packer.sv
// Generic synchronous FIFO; head word read straight from registered storage.
// Latency: push visible at head one cycle later.
// Backpressure: push_rdy low only when full with no pop in the same cycle.
module fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [W-1:0]     push_dat,
    output logic             push_rdy,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [W-1:0]     pop_dat,
    output logic [LVL_W-1:0] level
);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign pop_vld  = (level != '0);
    assign pop      = pop_vld && pop_rdy;
    assign push_rdy = (level != FULL_LVL) || pop;
    assign push     = push_vld && push_rdy;
    assign pop_dat  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// Packs random symbols LSB-first into words, buffers them, flags stuck source.
// Latency: a completed word is at the FIFO head the cycle after its last symbol.
// Backpressure: none on symbols; a word arriving at a full, non-draining FIFO is dropped.
module rand_byte_packer #(
    parameter int SYM_W      = 2,
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int RPT_LIMIT  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    rand_byte_packer_if.slave  bus
);
    localparam int SPW   = WORD_W / SYM_W;
    localparam int IDX_W = (SPW > 1) ? $clog2(SPW) : 1;
    localparam int RPT_W = $clog2(RPT_LIMIT + 1);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SPW - 1);
    localparam logic [RPT_W-1:0] RPT_MAX  = RPT_W'(RPT_LIMIT);
    localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);

    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] word_full;
    logic [IDX_W-1:0]  idx;
    logic              word_done;
    logic              push_rdy;
    logic              drop;

    logic [SYM_W-1:0]  prev_sym;
    logic              prev_vld;
    logic [RPT_W-1:0]  rpt;
    logic [RPT_W-1:0]  rpt_nxt;
    logic              overflow;
    logic              stuck;

    logic [WORD_W-1:0] head_dat;
    logic              head_vld;
    logic [LVL_W-1:0]  level;

    // Completed word includes the symbol being accepted this cycle.
    always_comb begin
        word_full = acc;
        word_full[idx*SYM_W +: SYM_W] = bus.i_sym;
    end

    assign word_done = bus.i_sym_valid && (idx == IDX_LAST);
    assign drop      = word_done && !push_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            idx <= '0;
        end else if (bus.i_sym_valid) begin
            acc <= word_full;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    fifo #(
        .W     (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (word_done),
        .push_dat (word_full),
        .push_rdy (push_rdy),
        .pop_vld  (head_vld),
        .pop_rdy  (bus.i_word_ready),
        .pop_dat  (head_dat),
        .level    (level)
    );

    always_comb begin
        rpt_nxt = RPT_ONE;
        if (prev_vld && (bus.i_sym == prev_sym))
            rpt_nxt = (rpt == RPT_MAX) ? rpt : rpt + 1'b1;
    end

    // Clear wins over same-cycle flag events, but a same-cycle symbol still seeds the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_sym <= '0;
            prev_vld <= 1'b0;
            rpt      <= '0;
            overflow <= 1'b0;
            stuck    <= 1'b0;
        end else if (bus.i_clr) begin
            overflow <= 1'b0;
            stuck    <= 1'b0;
            prev_vld <= bus.i_sym_valid;
            rpt      <= bus.i_sym_valid ? RPT_ONE : '0;
            if (bus.i_sym_valid) prev_sym <= bus.i_sym;
        end else begin
            if (drop) overflow <= 1'b1;
            if (bus.i_sym_valid) begin
                prev_sym <= bus.i_sym;
                prev_vld <= 1'b1;
                rpt      <= rpt_nxt;
                if (rpt_nxt == RPT_MAX) stuck <= 1'b1;
            end
        end
    end

    assign bus.o_word       = head_dat;
    assign bus.o_word_valid = head_vld;
    assign bus.o_level      = level;
    assign bus.o_overflow   = overflow;
    assign bus.o_stuck      = stuck;
endmodule

// File: tb/tb_rand_byte_packer.sv
// Randomized bench for rand_byte_packer against a queue-based reference model.
module tb_rand_byte_packer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    rand_byte_packer_if #(.SYM_W(2), .WORD_W(8), .FIFO_DEPTH(4)) bus ();

    rand_byte_packer #(
        .SYM_W(2), .WORD_W(8), .FIFO_DEPTH(4), .RPT_LIMIT(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] q[$];
    int         cur_word = 0;
    int         cur_n    = 0;
    bit         m_ovf    = 0;
    bit         m_stuck  = 0;
    int         run      = 0;
    bit         have_last = 0;
    logic [1:0] last_sym = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        cur_word = 0; cur_n = 0; m_ovf = 0; m_stuck = 0;
        run = 0; have_last = 0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".vld"},   32'(bus.o_word_valid), 32'(q.size() > 0));
        check({tag, ".level"}, 32'(bus.o_level),      32'(q.size()));
        check({tag, ".ovf"},   32'(bus.o_overflow),   32'(m_ovf));
        check({tag, ".stuck"}, 32'(bus.o_stuck),      32'(m_stuck));
        if (q.size() > 0) check({tag, ".word"}, 32'(bus.o_word), 32'(q[0]));
    endtask

    task automatic chk_zero(input string tag);
        check({tag, ".word"},  32'(bus.o_word),       0);
        check({tag, ".vld"},   32'(bus.o_word_valid), 0);
        check({tag, ".level"}, 32'(bus.o_level),      0);
        check({tag, ".ovf"},   32'(bus.o_overflow),   0);
        check({tag, ".stuck"}, 32'(bus.o_stuck),      0);
    endtask

    // One clock: drive inputs, advance the model, step, compare.
    task automatic cycle(input bit vld, input logic [1:0] s, input bit rdy, input bit clr,
                         input string tag);
        bit drop;
        drop = 0;
        bus.i_sym_valid  = vld;
        bus.i_sym        = s;
        bus.i_word_ready = rdy;
        bus.i_clr        = clr;
        if (rdy && q.size() > 0) void'(q.pop_front());
        if (vld) begin
            cur_word = cur_word | (int'(s) << (2 * cur_n));
            cur_n++;
            if (cur_n == 4) begin
                if (q.size() < 4) q.push_back(8'(cur_word));
                else drop = 1;
                cur_word = 0;
                cur_n    = 0;
            end
        end
        if (clr) begin
            m_ovf = 0; m_stuck = 0;
            run = vld ? 1 : 0;
            have_last = vld;
            last_sym = s;
        end else begin
            if (drop) m_ovf = 1;
            if (vld) begin
                if (have_last && s == last_sym) run = (run < 8) ? run + 1 : 8;
                else run = 1;
                last_sym = s; have_last = 1;
                if (run >= 8) m_stuck = 1;
            end
        end
        @(posedge clk); #1;
        check_model(tag);
    endtask

    // Asynchronous reset asserted mid-cycle with a symbol on the bus.
    task automatic do_reset(input string tag);
        #2;
        bus.i_sym_valid = 1'b1;
        bus.i_sym       = 2'($urandom);
        rst_n = 1'b0;
        #1;
        chk_zero({tag, ".imm"});
        model_reset();
        repeat (3) begin
            @(posedge clk); #1;
            chk_zero({tag, ".hold"});
        end
        bus.i_sym_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_zero({tag, ".rel"});
    endtask

    initial begin
        logic [7:0] w5;
        logic [1:0] rs;
        bus.i_sym_valid  = 1'b0;
        bus.i_sym        = '0;
        bus.i_word_ready = 1'b0;
        bus.i_clr        = 1'b0;
        @(posedge clk); #1;
        do_reset("rst0");

        // Pack order with gaps in the valid strobe
        cycle(1, 2'd1, 1, 0, "pk");
        cycle(0, 2'd3, 1, 0, "pk");
        cycle(1, 2'd2, 1, 0, "pk");
        cycle(1, 2'd3, 1, 0, "pk");
        cycle(0, 2'd2, 1, 0, "pk");
        cycle(1, 2'd0, 1, 0, "pk");
        check("pack_word",  32'(bus.o_word),       32'h39);
        check("pack_level", 32'(bus.o_level),      1);
        cycle(0, 2'd0, 1, 0, "pk_after");
        check("pack_one_cycle", 32'(bus.o_word_valid), 0);

        // Overflow with consumer stalled
        for (int i = 0; i < 20; i++) cycle(1, (i % 2 == 0) ? 2'd1 : 2'd2, 0, 0, "ov");
        check("ov_level", 32'(bus.o_level),    4);
        check("ov_flag",  32'(bus.o_overflow), 1);
        cycle(0, 2'd0, 0, 1, "ov_clr");
        check("ov_clr_flag",  32'(bus.o_overflow), 0);
        check("ov_clr_level", 32'(bus.o_level),    4);
        for (int i = 0; i < 4; i++) begin
            check("ov_drain_word", 32'(bus.o_word), 32'h99);
            cycle(0, 2'd0, 1, 0, "ov_drain");
        end

        // Full FIFO: last symbol of the 5th word lands together with a pop
        for (int i = 0; i < 16; i++) cycle(1, 2'($urandom), 0, 0, "fp_fill");
        check("fp_full", 32'(bus.o_level), 4);
        for (int i = 0; i < 3; i++) cycle(1, 2'($urandom), 0, 0, "fp_part");
        cycle(1, 2'($urandom), 1, 0, "fp_pp");
        check("fp_level", 32'(bus.o_level),    4);
        check("fp_ovf",   32'(bus.o_overflow), 0);
        w5 = q[$];
        for (int i = 0; i < 4; i++) begin
            if (i == 3) check("fp_last_word", 32'(bus.o_word), 32'(w5));
            cycle(0, 2'd0, 1, 0, "fp_drain");
        end

        // Stuck detection and clear
        cycle(0, 2'd0, 1, 1, "st_clr0");
        for (int i = 0; i < 7; i++) begin
            cycle(1, 2'd2, 1, 0, "st_run");
            check("st_below", 32'(bus.o_stuck), 0);
        end
        cycle(1, 2'd2, 1, 0, "st_hit");
        check("st_set", 32'(bus.o_stuck), 1);
        cycle(1, 2'd1, 1, 0, "st_diff");
        check("st_sticky", 32'(bus.o_stuck), 1);
        cycle(0, 2'd0, 1, 1, "st_clr");
        check("st_cleared", 32'(bus.o_stuck), 0);
        for (int i = 0; i < 7; i++) begin
            cycle(1, 2'd1, 1, 0, "st_run2");
            check("st_below2", 32'(bus.o_stuck), 0);
        end

        // Reset mid-word
        do_reset("rst1");
        cycle(1, 2'd1, 0, 0, "rm_pre");
        cycle(1, 2'd2, 0, 0, "rm_pre");
        do_reset("rst2");
        for (int i = 0; i < 4; i++) cycle(1, 2'd3, 0, 0, "rm");
        check("rm_word",  32'(bus.o_word),  32'hFF);
        check("rm_level", 32'(bus.o_level), 1);
        repeat (3) begin
            cycle(0, 2'd0, 0, 0, "rm_idle");
            check("rm_peak", 32'(bus.o_level), 1);
        end
        cycle(0, 2'd0, 1, 0, "rm_drain");

        // Randomized traffic, biased toward repeats to reach the stuck limit
        rs = 2'd0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 3) rs = 2'($urandom);
            cycle($urandom_range(0, 3) != 0, rs, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 39) == 0, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
